// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared FSM state and data pattern selectors for the RAM self-test engine
package ram_bist_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_ACK, RD_REQ, RD_ACK, DONE} state_t;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_ADR  = 2'd0;
  localparam mode_t MODE_NADR = 2'd1;
  localparam mode_t MODE_CHK  = 2'd2;
  localparam mode_t MODE_WALK = 2'd3;
endpackage

// File: rtl/ram_bist_if.sv
// ram_bist_if: pipelined Wishbone bus between the self-test master and the RAM controller
interface ram_bist_if #(parameter int ADR_W = 19, parameter int DAT_W = 16, parameter int SEL_W = DAT_W / 8);
  logic cyc_o;
  logic stb_o;
  logic we_o;
  logic [SEL_W-1:0] sel_o;
  logic [ADR_W-1:0] adr_o;
  logic [DAT_W-1:0] dat_o;
  logic [DAT_W-1:0] dat_i;
  logic ack_i;
  logic stall_i;
  modport master(output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, input dat_i, ack_i, stall_i);
  modport slave(input cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, output dat_i, ack_i, stall_i);
endinterface

// File: rtl/ram_bist_pattern.sv
// ram_bist_pattern: test data word for a given pattern mode and word address
module ram_bist_pattern import ram_bist_pkg::*; #(
  parameter int ADR_W = 19,
  parameter int DAT_W = 16
) (
  input  mode_t            mode,
  input  logic [ADR_W-1:0] adr,
  output logic [DAT_W-1:0] pat
);
  logic [ADR_W+DAT_W-1:0] wide;
  logic [DAT_W-1:0] lin;
  logic [DAT_W-1:0] chk;
  logic [DAT_W-1:0] walk;
  // widen first so the address is zero-extended or truncated for any ADR_W/DAT_W ratio
  assign wide = {{DAT_W{1'b0}}, adr};
  assign lin  = wide[DAT_W-1:0];
  assign chk  = adr[1] ? {(DAT_W/8){8'h55}} : {(DAT_W/8){8'hAA}};
  assign walk = DAT_W'(1) << (32'(adr) % 32'(DAT_W));
  assign pat  = mode == MODE_ADR ? lin : mode == MODE_NADR ? ~lin : mode == MODE_CHK ? chk : walk;
endmodule

// File: rtl/ram_bist.sv
// ram_bist: Wishbone-master SRAM self test, one write pass then one read-and-compare pass
module ram_bist import ram_bist_pkg::*; #(
  parameter int ADR_W   = 19,
  parameter int DAT_W   = 16,
  parameter int SEL_W   = DAT_W / 8,
  parameter int ERR_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  mode_t            mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic [ADR_W-1:0] fail_adr_o,
  output logic [DAT_W-1:0] fail_exp_o,
  output logic [DAT_W-1:0] fail_got_o,
  ram_bist_if.master       wb
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  mode_t mode;
  logic [TW-1:0] tcnt;
  logic [DAT_W-1:0] pat;
  ram_bist_pattern #(.ADR_W(ADR_W), .DAT_W(DAT_W)) u_pat (.mode(mode), .adr(wb.adr_o), .pat(pat));
  assign wb.sel_o = {SEL_W{wb.cyc_o}};
  assign wb.dat_o = wb.cyc_o ? pat : '0;
  assign pass_o = done_o && !timeout_o && err_count_o == '0;
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state <= IDLE;
      mode <= MODE_ADR;
      tcnt <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      timeout_o <= 1'b0;
      err_count_o <= '0;
      fail_adr_o <= '0;
      fail_exp_o <= '0;
      fail_got_o <= '0;
      wb.cyc_o <= 1'b0;
      wb.stb_o <= 1'b0;
      wb.we_o <= 1'b0;
      wb.adr_o <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (start_i) begin
            mode <= mode_i;
            err_count_o <= '0;
            fail_adr_o <= '0;
            fail_exp_o <= '0;
            fail_got_o <= '0;
            timeout_o <= 1'b0;
            busy_o <= 1'b1;
            done_o <= 1'b0;
            wb.adr_o <= '0;
            wb.cyc_o <= 1'b1;
            wb.stb_o <= 1'b1;
            wb.we_o <= 1'b1;
            state <= WR_REQ;
          end
        WR_REQ, RD_REQ:
          if (!wb.stall_i) begin
            wb.stb_o <= 1'b0;
            tcnt <= '0;
            state <= state == WR_REQ ? WR_ACK : RD_ACK;
          end
        WR_ACK, RD_ACK:
          if (wb.ack_i) begin
            if (state == RD_ACK && wb.dat_i != pat) begin
              if (err_count_o != '1) err_count_o <= err_count_o + 1'b1;
              // a zero count means this is the first mismatch of the run
              if (err_count_o == '0) begin
                fail_adr_o <= wb.adr_o;
                fail_exp_o <= pat;
                fail_got_o <= wb.dat_i;
              end
            end
            if (wb.adr_o != '1) begin
              wb.adr_o <= wb.adr_o + 1'b1;
              wb.stb_o <= 1'b1;
              state <= state == WR_ACK ? WR_REQ : RD_REQ;
            end else if (state == WR_ACK) begin
              wb.adr_o <= '0;
              wb.stb_o <= 1'b1;
              wb.we_o <= 1'b0;
              state <= RD_REQ;
            end else begin
              wb.cyc_o <= 1'b0;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state <= DONE;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            wb.cyc_o <= 1'b0;
            wb.we_o <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            timeout_o <= 1'b1;
            state <= DONE;
          end else tcnt <= tcnt + 1'b1;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: scoreboard bench, expected bus requests and run results queued at start, checked by monitors
module tb_ram_bist;
  import ram_bist_pkg::*;
  typedef struct {logic we; int adr; logic [15:0] dat;} req_t;
  typedef struct {int cyc; logic pass; logic tmo; int err; int fadr; logic [15:0] fexp; logic [15:0] fgot;} res_t;
  logic clk = 1'b0, rst = 1'b1, start4 = 1'b0, start5 = 1'b0;
  mode_t mode = MODE_ADR;
  logic busy4, done4, pass4, tmo4, busy5, done5, pass5, tmo5;
  logic [2:0] err4;
  logic [15:0] err5;
  logic [3:0] fadr4;
  logic [4:0] fadr5;
  logic [15:0] fexp4, fgot4, fexp5, fgot5;
  int checks = 0, errors = 0, tick = 0, t0_4 = 0, t0_5 = 0, noack = -1, scnt = 0;
  logic fault = 1'b0, zero_rd = 1'b0, pd4 = 1'b0, pd5 = 1'b0, pst = 1'b0, we_s = 1'b0;
  logic [4:0] adr_s = '0;
  logic [15:0] dat_s = '0;
  logic [15:0] mem4 [16];
  logic [15:0] mem5 [32];
  req_t rq4[$], rq5[$];
  res_t rs4[$], rs5[$];
  ram_bist_if #(.ADR_W(4), .DAT_W(16)) w4();
  ram_bist_if #(.ADR_W(5), .DAT_W(16)) w5();
  ram_bist #(.ADR_W(4), .DAT_W(16), .ERR_W(3), .TIMEOUT(8)) dut4 (
    .clk_i(clk), .reset_i(rst), .start_i(start4), .mode_i(mode), .busy_o(busy4), .done_o(done4),
    .pass_o(pass4), .timeout_o(tmo4), .err_count_o(err4), .fail_adr_o(fadr4), .fail_exp_o(fexp4),
    .fail_got_o(fgot4), .wb(w4));
  ram_bist #(.ADR_W(5), .DAT_W(16)) dut5 (
    .clk_i(clk), .reset_i(rst), .start_i(start5), .mode_i(mode), .busy_o(busy5), .done_o(done5),
    .pass_o(pass5), .timeout_o(tmo5), .err_count_o(err5), .fail_adr_o(fadr5), .fail_exp_o(fexp5),
    .fail_got_o(fgot5), .wb(w5));
  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;
  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction
  function automatic logic [15:0] exp_pat(int m, int a);
    logic [15:0] v = 16'(a);
    case (m)
      0: return v;
      1: return ~v;
      2: return v[1] ? 16'h5555 : 16'hAAAA;
      default: return 16'h1 << (a % 16);
    endcase
  endfunction
  function automatic void push(bit d5, int m, int nw, int nr);
    req_t r;
    for (int i = 0; i < nw + nr; i++) begin
      r.we = i < nw;
      r.adr = i < nw ? i : i - nw;
      r.dat = exp_pat(m, r.adr);
      if (d5) rq5.push_back(r);
      else rq4.push_back(r);
    end
  endfunction
  function automatic void cmp_req(string t, req_t r, logic we, int adr, logic [15:0] dat, int sel);
    chk({t, "_we"}, 32'(we), 32'(r.we));
    chk({t, "_adr"}, adr, r.adr);
    chk({t, "_dat"}, 32'(dat), 32'(r.dat));
    chk({t, "_sel"}, sel, 3);
  endfunction
  function automatic void cmp_res(string t, res_t r, int c, logic p, logic tm, int e, int fa,
                                  logic [15:0] fe, logic [15:0] fg, logic cy);
    chk({t, "_done_cycle"}, c, r.cyc);
    chk({t, "_pass"}, 32'(p), 32'(r.pass));
    chk({t, "_timeout"}, 32'(tm), 32'(r.tmo));
    chk({t, "_err_count"}, e, r.err);
    chk({t, "_fail_adr"}, fa, r.fadr);
    chk({t, "_fail_exp"}, 32'(fe), 32'(r.fexp));
    chk({t, "_fail_got"}, 32'(fg), 32'(r.fgot));
    chk({t, "_cyc_low"}, 32'(cy), 0);
  endfunction
  // ideal RAM for dut4 with injectable faults, acking one cycle after acceptance
  always @(posedge clk)
    if (rst || !(w4.stb_o && !w4.stall_i)) w4.ack_i <= 1'b0;
    else begin
      if (w4.we_o) mem4[w4.adr_o] <= w4.dat_o;
      w4.ack_i <= !(w4.we_o && int'(w4.adr_o) == noack);
      w4.dat_i <= zero_rd ? 16'h0 : mem4[w4.adr_o] | ((fault && w4.adr_o == 4'd5) ? 16'h0008 : 16'h0000);
    end
  assign w4.stall_i = 1'b0;
  // dut5 RAM stalls every request for three cycles before accepting it
  always @(posedge clk)
    if (rst) begin
      scnt <= 0;
      w5.stall_i <= 1'b1;
      w5.ack_i <= 1'b0;
    end else if (w5.stb_o && !w5.stall_i) begin
      scnt <= 0;
      w5.stall_i <= 1'b1;
      w5.ack_i <= 1'b1;
      if (w5.we_o) mem5[w5.adr_o] <= w5.dat_o;
      w5.dat_i <= mem5[w5.adr_o];
    end else begin
      w5.ack_i <= 1'b0;
      if (w5.stb_o) begin
        scnt <= scnt + 1;
        w5.stall_i <= scnt + 1 < 3;
      end
    end
  always @(negedge clk) begin
    if (w4.stb_o && !w4.stall_i) begin
      if (rq4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req4_extra: got request at adr %0d, expected none", w4.adr_o);
      end else begin
        cmp_req("req4", rq4[0], w4.we_o, int'(w4.adr_o), w4.dat_o, int'(w4.sel_o));
        void'(rq4.pop_front());
      end
    end
    if (done4 && !pd4) begin
      if (rs4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res4_extra: got done_o, expected none");
      end else begin
        cmp_res("res4", rs4[0], tick - t0_4, pass4, tmo4, int'(err4), int'(fadr4), fexp4, fgot4, w4.cyc_o);
        void'(rs4.pop_front());
      end
    end
    pd4 <= done4;
  end
  always @(negedge clk) begin
    if (pst) begin
      chk("stall_stb", 32'(w5.stb_o), 1);
      chk("stall_we", 32'(w5.we_o), 32'(we_s));
      chk("stall_adr", 32'(w5.adr_o), 32'(adr_s));
      chk("stall_dat", 32'(w5.dat_o), 32'(dat_s));
    end
    pst <= w5.stb_o && w5.stall_i;
    we_s <= w5.we_o;
    adr_s <= w5.adr_o;
    dat_s <= w5.dat_o;
    if (w5.stb_o && !w5.stall_i) begin
      if (w5.adr_o == 5'd17) chk("walk_adr17", 32'(w5.dat_o), 32'h0002);
      if (rq5.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req5_extra: got request at adr %0d, expected none", w5.adr_o);
      end else begin
        cmp_req("req5", rq5[0], w5.we_o, int'(w5.adr_o), w5.dat_o, int'(w5.sel_o));
        void'(rq5.pop_front());
      end
    end
    if (done5 && !pd5) begin
      if (rs5.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res5_extra: got done_o, expected none");
      end else begin
        cmp_res("res5", rs5[0], tick - t0_5, pass5, tmo5, int'(err5), int'(fadr5), fexp5, fgot5, w5.cyc_o);
        void'(rs5.pop_front());
      end
    end
    pd5 <= done5;
  end
  task automatic go(bit d5, mode_t m);
    @(posedge clk);
    #1;
    mode = m;
    if (d5) begin start5 = 1'b1; t0_5 = tick; end
    else begin start4 = 1'b1; t0_4 = tick; end
    @(posedge clk);
    #1;
    start4 = 1'b0;
    start5 = 1'b0;
  endtask
  task automatic wait_done(bit d5);
    for (int i = 0; i < 2000 && (d5 ? rs5.size() : rs4.size()) != 0; i++) @(negedge clk);
    if ((d5 ? rs5.size() : rs4.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL done_wait%0d: got no done_o in 2000 cycles, expected done_o", d5 ? 5 : 4);
      rs4.delete();
      rs5.delete();
    end
  endtask
  task automatic wait_req4(logic we, int a);
    bit found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      found = w4.stb_o && w4.we_o == we && int'(w4.adr_o) == a;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL req_wait: got no request we=%0d adr=%0d in 500 cycles, expected one", we, a);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy4", 32'(busy4), 0);
    chk("rst_done4", 32'(done4), 0);
    chk("rst_pass4", 32'(pass4), 0);
    chk("rst_tmo4", 32'(tmo4), 0);
    chk("rst_err4", 32'(err4), 0);
    chk("rst_cyc4", 32'(w4.cyc_o), 0);
    chk("rst_stb4", 32'(w4.stb_o), 0);
    chk("rst_dat4", 32'(w4.dat_o), 0);
    chk("rst_busy5", 32'(busy5), 0);
    chk("rst_done5", 32'(done5), 0);
    push(0, 0, 16, 16);
    rs4.push_back('{65, 1'b1, 1'b0, 0, 0, 16'h0, 16'h0});
    go(0, MODE_ADR);
    wait_done(0);
    fault = 1'b1;
    push(0, 0, 16, 16);
    rs4.push_back('{65, 1'b0, 1'b0, 1, 5, 16'h0005, 16'h000D});
    go(0, MODE_ADR);
    wait_done(0);
    fault = 1'b0;
    zero_rd = 1'b1;
    push(0, 1, 16, 16);
    rs4.push_back('{65, 1'b0, 1'b0, 7, 0, 16'hFFFF, 16'h0000});
    go(0, MODE_NADR);
    wait_done(0);
    zero_rd = 1'b0;
    noack = 2;
    push(0, 0, 3, 0);
    rs4.push_back('{14, 1'b0, 1'b1, 0, 0, 16'h0, 16'h0});
    go(0, MODE_ADR);
    wait_done(0);
    noack = -1;
    push(0, 0, 16, 16);
    rs4.push_back('{65, 1'b1, 1'b0, 0, 0, 16'h0, 16'h0});
    go(0, MODE_ADR);
    wait_req4(1'b1, 7);
    start4 = 1'b1;
    mode = MODE_NADR;
    @(negedge clk);
    start4 = 1'b0;
    mode = MODE_ADR;
    wait_done(0);
    push(1, 3, 32, 32);
    rs5.push_back('{321, 1'b1, 1'b0, 0, 0, 16'h0, 16'h0});
    go(1, MODE_WALK);
    wait_done(1);
    fault = 1'b1;
    push(0, 0, 16, 16);
    go(0, MODE_ADR);
    wait_req4(1'b0, 8);
    chk("pre_rst_err4", 32'(err4), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cyc4", 32'(w4.cyc_o), 0);
    chk("midrst_stb4", 32'(w4.stb_o), 0);
    chk("midrst_busy4", 32'(busy4), 0);
    chk("midrst_done4", 32'(done4), 0);
    chk("midrst_err4", 32'(err4), 0);
    rst = 1'b0;
    rq4.delete();
    fault = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_after_rst", 32'(w4.cyc_o), 0);
    chk("left_req", rq4.size() + rq5.size(), 0);
    chk("left_res", rs4.size() + rs5.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_bist.md
Name: ram_bist

Overview:
- Parametrised Wishbone-master SRAM self-test engine; successor to the free-running counter/LED RAM exerciser.
- Drives one full write pass, then one full read-and-compare pass over 2^ADR_W words, using a selectable data pattern.
- Reports pass/fail, a saturating error count, first-failure details and bus timeout.
- Sits between board top level and ramcon (connects to ramcon's pipelined Wishbone slave port).

Parameters:
- ADR_W, 19, word address width (adr_o[ADR_W:1]).
- DAT_W, 16, data width; multiple of 8.
- SEL_W, DAT_W/8, byte-select width.
- ERR_W, 16, error counter width.
- TIMEOUT, 255, max cycles waiting for ack_i after acceptance.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous active-high reset.
- start_i  in  1  begin test (sampled only when not busy).
- mode_i  in  2  pattern select, captured at start.
- busy_o  out  1  test in progress.
- done_o  out  1  test finished; level, held until next start or reset.
- pass_o  out  1  valid when done_o: no mismatches and no timeout.
- timeout_o  out  1  run aborted on ack timeout.
- err_count_o  out  ERR_W  mismatch count, saturating.
- fail_adr_o  out  ADR_W  address of first mismatch.
- fail_exp_o  out  DAT_W  expected data at first mismatch.
- fail_got_o  out  DAT_W  read data at first mismatch.
- cyc_o, stb_o, we_o  out  1  Wishbone master controls.
- sel_o  out  SEL_W  all ones during transfers.
- adr_o  out  ADR_W  word address.
- dat_o  out  DAT_W  write data.
- dat_i  in  DAT_W  read data.
- ack_i, stall_i  in  1  Wishbone slave responses.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-run drops cyc_o/stb_o on the next edge and discards results.
- Pattern P(mode, a):
  - 0: a zero-extended or truncated to DAT_W.
  - 1: bitwise ~P(0, a).
  - 2: alternating 0xAA../0x55.. selected by a[1] (1 gives 0x55..).
  - 3: walking one, 1 << (a mod DAT_W).
- States: IDLE, WR_REQ, WR_ACK, RD_REQ, RD_ACK, DONE.
- IDLE/DONE + start_i: clear counters, fail_* and timeout_o; set busy_o=1, done_o=0, adr=0; go to WR_REQ. start_i while busy is ignored.
- *_REQ: cyc_o=stb_o=1, we_o=1 in WR_REQ and 0 in RD_REQ, dat_o=P(mode, adr). The request is accepted on a cycle with stb_o && !stall_i; then go to *_ACK with stb_o=0 and cyc_o=1. adr_o, dat_o and we_o are stable while stalled.
- *_ACK: ack_i is sampled from the cycle after acceptance. On ack:
  - if adr is not the last address, adr+1 and return to the same *_REQ;
  - else WR_ACK goes to RD_REQ with adr=0, and RD_ACK goes to DONE.
- RD_ACK compare: if dat_i != P(mode, adr), err_count_o increments (saturating at all ones). The first mismatch only loads fail_adr/exp/got.
- Timeout: a per-transaction counter runs in *_ACK. When it reaches TIMEOUT without ack, go to DONE with timeout_o=1. Ack on exactly the TIMEOUT-th cycle counts as success.
- DONE: cyc_o=stb_o=0, busy_o=0, done_o=1, pass_o = (err==0 && !timeout).
- Latency with a zero-stall slave acking one cycle after acceptance:
  - 2 cycles per transfer;
  - first stb_o 1 cycle after start_i is sampled;
  - done_o rises 4*2^ADR_W+1 cycles after start.
- Address wrap: the last address is all ones; the counter is never allowed to wrap inside a pass.

Decomposition:
- ram_bist_pkg: state enum, mode constants (MODE_ADR, MODE_NADR, MODE_CHK, MODE_WALK).
- Sub-module ram_bist_pattern: combinational P(mode, adr), parametrised by ADR_W/DAT_W. Shared by the write data path and the compare path.

Test Plan:
- ADR_W=4, DAT_W=16, mode 0, ideal RAM model acking 1 cycle after accept:
  - 16 writes with dat_o=adr, then 16 reads;
  - done_o at cycle 65 after start, pass_o=1, err_count_o=0.
- Same, model forces bit 3 of address 5 read data high:
  - err_count_o=1, fail_adr_o=5, fail_exp_o=0x0005, fail_got_o=0x000D, pass_o=0.
- mode 3, stall_i high 3 cycles per request:
  - stb_o, adr_o and dat_o are held stable while stalled;
  - dat_o at adr 17 (ADR_W=5) is 0x0002;
  - pass_o=1.
- TIMEOUT=8, model never acks the write to address 2:
  - after 8 cycles in WR_ACK, cyc_o=0, done_o=1, timeout_o=1, pass_o=0.
- ERR_W=3, mode 1, model returns 0 for every read: err_count_o saturates at 7, fail_adr_o=0, fail_exp_o=0xFFFF.
- Reset pulse during read pass, plus start_i pulsed mid-run in a separate run:
  - reset: next cycle cyc_o=stb_o=busy_o=done_o=0, err_count_o=0;
  - start_i while busy has no effect on adr_o progression.
